// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I main control FSM:
// opcodes, ALU op codes, mux selects, state encoding and the control word.
package mc_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_REGA   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO   = 2'b10;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b11;

  localparam logic [1:0] SRC_B_REGB = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] PC_SRC_ALU     = 2'b00;
  localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
  localparam logic [1:0] PC_SRC_JALR    = 2'b10;

  localparam logic [1:0] WB_ALU_OUT = 2'b00;
  localparam logic [1:0] WB_MDR     = 2'b01;
  localparam logic [1:0] WB_PC      = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_HALT     = 4'd14
  } state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control word decode. Only the memory completion
// strobes and the branch PC load look at inputs; everything else is Moore.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   br_taken,
  output ctrl_t  cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.i_or_d    = 1'b0;
        cw.alu_src_a = SRC_A_PC;
        cw.alu_src_b = SRC_B_FOUR;
        cw.alu_op    = ALU_OP_ADD;
        cw.pc_src    = PC_SRC_ALU;
        cw.ir_write  = mem_ready;
        cw.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // ALUOut captures old_pc + imm as the branch/JAL target.
        cw.alu_src_a = SRC_A_OLD_PC;
        cw.alu_src_b = SRC_B_IMM;
        cw.alu_op    = ALU_OP_ADD;
      end
      S_EXEC_R: begin
        cw.alu_src_a = SRC_A_REGA;
        cw.alu_src_b = SRC_B_REGB;
        cw.alu_op    = ALU_OP_RTYPE;
      end
      S_EXEC_I: begin
        cw.alu_src_a = SRC_A_REGA;
        cw.alu_src_b = SRC_B_IMM;
        cw.alu_op    = ALU_OP_ITYPE;
      end
      S_MEM_ADDR: begin
        cw.alu_src_a = SRC_A_REGA;
        cw.alu_src_b = SRC_B_IMM;
        cw.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        cw.mem_read = 1'b1;
        cw.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        cw.mem_write = 1'b1;
        cw.i_or_d    = 1'b1;
      end
      S_WB_ALU: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = WB_ALU_OUT;
      end
      S_WB_MEM: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = WB_MDR;
      end
      S_BRANCH: begin
        cw.alu_src_a = SRC_A_REGA;
        cw.alu_src_b = SRC_B_REGB;
        cw.alu_op    = ALU_OP_SUB;
        cw.pc_src    = PC_SRC_ALU_OUT;
        cw.pc_write  = br_taken;
      end
      S_JAL: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = WB_PC;
        cw.pc_src     = PC_SRC_ALU_OUT;
        cw.pc_write   = 1'b1;
      end
      S_JALR: begin
        // Link writes the pre-update PC; the new PC lands at the same edge.
        cw.alu_src_a  = SRC_A_REGA;
        cw.alu_src_b  = SRC_B_IMM;
        cw.alu_op     = ALU_OP_ADD;
        cw.pc_src     = PC_SRC_JALR;
        cw.pc_write   = 1'b1;
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = WB_PC;
      end
      S_LUI: begin
        cw.alu_src_a = SRC_A_ZERO;
        cw.alu_src_b = SRC_B_IMM;
        cw.alu_op    = ALU_OP_ADD;
      end
      S_AUIPC: begin
        cw.alu_src_a = SRC_A_OLD_PC;
        cw.alu_src_b = SRC_B_IMM;
        cw.alu_op    = ALU_OP_ADD;
      end
      S_HALT: begin
        cw.halted = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Main control FSM of the multicycle RV32I core: state register, next-state
// logic, retired-instruction counter and reset gating of the control word.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W           = 32,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  // Memory handshake: mem_read/mem_write act as valid and stay high until
  // the cycle mem_ready is seen; that cycle is the transfer and the state
  // advances at its closing edge.
  state_t state;
  state_t state_next;
  ctrl_t  dec_cw;
  ctrl_t  cw;

  mc_ctrl_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .br_taken  (br_taken),
    .cw        (dec_cw)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:               state_next = S_EXEC_R;
          OP_I:               state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_next = S_MEM_ADDR;
          OP_BRANCH:          state_next = S_BRANCH;
          OP_JAL:             state_next = S_JAL;
          OP_JALR:            state_next = S_JALR;
          OP_LUI:             state_next = S_LUI;
          OP_AUIPC:           state_next = S_AUIPC;
          OP_SYSTEM:          state_next = S_HALT;
          default:            state_next = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state_next = S_WB_ALU;
      S_MEM_ADDR: state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_next = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR: state_next = S_FETCH;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= state_next;
      if (state != S_FETCH && state_next == S_FETCH)
        instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cw = rst ? '0 : dec_cw;

  assign mem_read   = cw.mem_read;
  assign mem_write  = cw.mem_write;
  assign i_or_d     = cw.i_or_d;
  assign ir_write   = cw.ir_write;
  assign pc_write   = cw.pc_write;
  assign pc_src     = cw.pc_src;
  assign alu_src_a  = cw.alu_src_a;
  assign alu_src_b  = cw.alu_src_b;
  assign alu_op     = cw.alu_op;
  assign reg_write  = cw.reg_write;
  assign mem_to_reg = cw.mem_to_reg;
  assign halted     = cw.halted;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-cycle expected control word and instret are queued
// by the instruction drivers and compared on the falling edge.
module tb_mc_ctrl;

  localparam int CNT_W = 4;

  localparam logic [6:0] T_R      = 7'b0110011;
  localparam logic [6:0] T_I      = 7'b0010011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_SYSTEM = 7'b1110011;
  localparam logic [6:0] T_ILLEGAL = 7'b1111111;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [6:0]       opcode = '0;
  logic             br_taken = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0]       pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg;
  logic             reg_write, halted;
  logic [CNT_W-1:0] instret;

  logic [20:0]      exp_q[$];
  string            tag_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  int               n_checks = 0;
  int               n_fails = 0;

  mc_ctrl #(.CNT_W(CNT_W), .HALT_ON_ILLEGAL(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .br_taken   (br_taken),
    .mem_ready  (mem_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .halted     (halted),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Word layout: mr mw iod irw pcw pc_src a b op rw m2r halted
  function automatic logic [16:0] mk(input int mr, input int mw, input int iod, input int irw,
                                     input int pcw, input int pcs, input int sa, input int sb,
                                     input int op, input int rw, input int m2r, input int h);
    logic [16:0] w;
    w = {mr[0], mw[0], iod[0], irw[0], pcw[0], pcs[1:0], sa[1:0], sb[1:0], op[1:0],
         rw[0], m2r[1:0], h[0]};
    return w;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input logic [6:0] op, input logic bt, input logic mr,
                     input logic [16:0] w, input string tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    opcode = op;
    br_taken = bt;
    mem_ready = mr;
    exp_q.push_back({w, exp_cnt});
    tag_q.push_back(tag);
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      mem_ready = rb();
      br_taken = rb();
      exp_q.push_back({17'b0, (i == 0) ? exp_cnt : {CNT_W{1'b0}}});
      tag_q.push_back("reset");
    end
    exp_cnt = '0;
  endtask

  task automatic run(input logic [6:0] op, input logic bt, input int fstall,
                     input int mstall, input bit abort);
    bit retire;
    retire = 1'b1;
    for (int i = 0; i < fstall; i++)
      cyc(op, rb(), 1'b0, mk(1,0,0,0,0,0,0,1,0,0,0,0), "fetch_wait");
    cyc(op, rb(), 1'b1, mk(1,0,0,1,1,0,0,1,0,0,0,0), "fetch");
    cyc(op, rb(), rb(), mk(0,0,0,0,0,0,3,2,0,0,0,0), "decode");
    case (op)
      T_R: begin
        cyc(op, rb(), rb(), mk(0,0,0,0,0,0,1,0,2,0,0,0), "exec_r");
        cyc(op, rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,0,0), "wb_alu");
      end
      T_I: begin
        cyc(op, rb(), rb(), mk(0,0,0,0,0,0,1,2,3,0,0,0), "exec_i");
        cyc(op, rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,0,0), "wb_alu");
      end
      T_LUI: begin
        cyc(op, rb(), rb(), mk(0,0,0,0,0,0,2,2,0,0,0,0), "lui");
        cyc(op, rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,0,0), "wb_alu");
      end
      T_AUIPC: begin
        cyc(op, rb(), rb(), mk(0,0,0,0,0,0,3,2,0,0,0,0), "auipc");
        cyc(op, rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,0,0), "wb_alu");
      end
      T_LOAD: begin
        cyc(op, rb(), rb(), mk(0,0,0,0,0,0,1,2,0,0,0,0), "mem_addr");
        for (int i = 0; i < mstall; i++)
          cyc(op, rb(), 1'b0, mk(1,0,1,0,0,0,0,0,0,0,0,0), "mem_rd_wait");
        cyc(op, rb(), 1'b1, mk(1,0,1,0,0,0,0,0,0,0,0,0), "mem_rd");
        cyc(op, rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,1,0), "wb_mem");
      end
      T_STORE: begin
        cyc(op, rb(), rb(), mk(0,0,0,0,0,0,1,2,0,0,0,0), "mem_addr");
        for (int i = 0; i < mstall; i++)
          cyc(op, rb(), 1'b0, mk(0,1,1,0,0,0,0,0,0,0,0,0), "mem_wr_wait");
        if (abort) retire = 1'b0;
        else cyc(op, rb(), 1'b1, mk(0,1,1,0,0,0,0,0,0,0,0,0), "mem_wr");
      end
      T_BRANCH: cyc(op, bt, rb(), mk(0,0,0,0,bt,1,1,0,1,0,0,0), "branch");
      T_JAL:    cyc(op, rb(), rb(), mk(0,0,0,0,1,1,0,0,0,1,2,0), "jal");
      T_JALR:   cyc(op, rb(), rb(), mk(0,0,0,0,1,2,1,2,0,1,2,0), "jalr");
      default: begin
        retire = 1'b0;
        for (int i = 0; i < 20; i++)
          cyc(op, rb(), rb(), mk(0,0,0,0,0,0,0,0,0,0,0,1), "halt");
      end
    endcase
    if (retire) exp_cnt = exp_cnt + 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [20:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {11'b0, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_op, reg_write, mem_to_reg, halted, instret}, {11'b0, e});
    end
  end

  logic [6:0] legal [10];

  initial begin
    legal = '{T_R, T_I, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR, T_LUI, T_AUIPC, T_R};
    repeat (2) @(posedge clk);
    rst_cycles(2);
    run(T_R, 1'b0, 0, 0, 1'b0);
    run(T_I, 1'b0, 1, 0, 1'b0);
    run(T_LOAD, 1'b0, 0, 3, 1'b0);
    run(T_STORE, 1'b0, 2, 1, 1'b0);
    run(T_BRANCH, 1'b0, 0, 0, 1'b0);
    run(T_BRANCH, 1'b1, 0, 0, 1'b0);
    run(T_JAL, 1'b0, 0, 0, 1'b0);
    run(T_JALR, 1'b0, 0, 0, 1'b0);
    run(T_LUI, 1'b0, 0, 0, 1'b0);
    run(T_AUIPC, 1'b0, 0, 0, 1'b0);
    for (int k = 0; k < 20; k++)
      run(legal[$urandom_range(0, 9)], rb(), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    run(T_STORE, 1'b0, 0, 2, 1'b1);
    rst_cycles(1);
    run(T_R, 1'b0, 0, 0, 1'b0);
    run(T_ILLEGAL, 1'b0, 0, 0, 1'b0);
    rst_cycles(1);
    run(T_I, 1'b0, 0, 0, 1'b0);
    run(T_SYSTEM, 1'b0, 0, 0, 1'b0);
    rst_cycles(1);
    run(T_JAL, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    #1;
    check("drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
